// File: rtl/intr_ctrl85_pkg.sv
// Shared constants for the 8085 interrupt controller:
// source codes, restart vectors and SIM/RIM bit positions.
package intr_ctrl85_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_TRAP = 3'd1,
        SRC_R75  = 3'd2,
        SRC_R65  = 3'd3,
        SRC_R55  = 3'd4,
        SRC_INTR = 3'd5
    } int_src_e;

    localparam logic [15:0] VEC_TRAP = 16'h0024;
    localparam logic [15:0] VEC_R75  = 16'h003C;
    localparam logic [15:0] VEC_R65  = 16'h0034;
    localparam logic [15:0] VEC_R55  = 16'h002C;

    localparam int SIM_SOD  = 7;
    localparam int SIM_SDE  = 6;
    localparam int SIM_R75  = 4;
    localparam int SIM_MSE  = 3;

endpackage

// File: rtl/intr_ctrl85_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin,
// with a single-cycle rising-edge pulse on the synced level.
module intr_ctrl85_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] q;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            prev <= 1'b0;
        end else begin
            q    <= {q[STAGES-2:0], din};
            prev <= q[STAGES-1];
        end
    end

    assign level = q[STAGES-1];
    assign rise  = q[STAGES-1] & ~prev;

endmodule

// File: rtl/intr_ctrl85.sv
// 8085 interrupt controller: synchronisers, masks, RST7.5/TRAP
// latches, IE handling, priority encoder, SIM/RIM and SOD.
module intr_ctrl85
    import intr_ctrl85_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int VECSIZE     = 16
) (
    input  logic               CLK,
    input  logic               RST_,
    input  logic               TRAP,
    input  logic               RST75,
    input  logic               RST65,
    input  logic               RST55,
    input  logic               INTR,
    input  logic               SID,
    input  logic               ei,
    input  logic               di,
    input  logic               inst_end,
    input  logic               sim_wr,
    input  logic [7:0]         sim_d,
    input  logic               int_ack,
    output logic               int_req,
    output logic [2:0]         int_src,
    output logic               int_ext,
    output logic [VECSIZE-1:0] int_vec,
    output logic [7:0]         rim_q,
    output logic               SOD
);

    logic trap_s, trap_rise;
    logic r75_s, r75_rise;
    logic r65_s, r65_rise;
    logic r55_s, r55_rise;
    logic intr_s, intr_rise;

    intr_ctrl85_sync_edge #(.STAGES(SYNC_STAGES)) u_trap (
        .clk(CLK), .rst_n(RST_), .din(TRAP),
        .level(trap_s), .rise(trap_rise)
    );
    intr_ctrl85_sync_edge #(.STAGES(SYNC_STAGES)) u_r75 (
        .clk(CLK), .rst_n(RST_), .din(RST75),
        .level(r75_s), .rise(r75_rise)
    );
    intr_ctrl85_sync_edge #(.STAGES(SYNC_STAGES)) u_r65 (
        .clk(CLK), .rst_n(RST_), .din(RST65),
        .level(r65_s), .rise(r65_rise)
    );
    intr_ctrl85_sync_edge #(.STAGES(SYNC_STAGES)) u_r55 (
        .clk(CLK), .rst_n(RST_), .din(RST55),
        .level(r55_s), .rise(r55_rise)
    );
    intr_ctrl85_sync_edge #(.STAGES(SYNC_STAGES)) u_intr (
        .clk(CLK), .rst_n(RST_), .din(INTR),
        .level(intr_s), .rise(intr_rise)
    );

    logic [SYNC_STAGES-1:0] sid_q;

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) sid_q <= '0;
        else       sid_q <= {sid_q[SYNC_STAGES-2:0], SID};
    end

    logic       ie, ei_pend, ie_save, show_save;
    logic       r75_latch, trap_pend, sod_q;
    logic [2:0] mask;

    int_src_e src;

    always_comb begin
        src = SRC_NONE;
        if (trap_pend)                      src = SRC_TRAP;
        else if (r75_latch & ~mask[2] & ie) src = SRC_R75;
        else if (r65_s & ~mask[1] & ie)     src = SRC_R65;
        else if (r55_s & ~mask[0] & ie)     src = SRC_R55;
        else if (intr_s & ie)               src = SRC_INTR;
    end

    logic ack_ok, ack_trap, ack_r75;
    logic sim_mask, sim_clr75, sim_sod;

    assign ack_ok    = int_ack & (src != SRC_NONE);
    assign ack_trap  = ack_ok & (src == SRC_TRAP);
    assign ack_r75   = ack_ok & (src == SRC_R75);
    assign sim_mask  = sim_wr & sim_d[SIM_MSE];
    assign sim_clr75 = sim_wr & sim_d[SIM_R75];
    assign sim_sod   = sim_wr & sim_d[SIM_SDE];

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            ie        <= 1'b0;
            ei_pend   <= 1'b0;
            ie_save   <= 1'b0;
            show_save <= 1'b0;
            r75_latch <= 1'b0;
            trap_pend <= 1'b0;
            sod_q     <= 1'b0;
            mask      <= 3'b111;
        end else begin
            if (sim_mask) mask  <= sim_d[2:0];
            if (sim_sod)  sod_q <= sim_d[SIM_SOD];

            // A new edge must not be lost to a clear in the same cycle
            r75_latch <= r75_rise |
                         (r75_latch & ~sim_clr75 & ~ack_r75);
            trap_pend <= trap_rise |
                         (trap_pend & trap_s & ~ack_trap);

            if (di || ack_ok) begin
                ie      <= 1'b0;
                ei_pend <= 1'b0;
            end else begin
                if (ei_pend && inst_end) begin
                    ie      <= 1'b1;
                    ei_pend <= 1'b0;
                end
                if (ei) ei_pend <= 1'b1;
            end

            if (ack_trap) begin
                ie_save   <= ie;
                show_save <= 1'b1;
            end else if (ei || di || ack_ok) begin
                show_save <= 1'b0;
            end
        end
    end

    always_comb begin
        int_vec = '0;
        unique case (src)
            SRC_TRAP: int_vec = VECSIZE'(VEC_TRAP);
            SRC_R75:  int_vec = VECSIZE'(VEC_R75);
            SRC_R65:  int_vec = VECSIZE'(VEC_R65);
            SRC_R55:  int_vec = VECSIZE'(VEC_R55);
            default:  int_vec = '0;
        endcase
    end

    assign int_req = (src != SRC_NONE);
    assign int_src = src;
    assign int_ext = (src == SRC_INTR);
    assign SOD     = sod_q;
    assign rim_q   = {sid_q[SYNC_STAGES-1], r75_latch, r65_s, r55_s,
                      show_save ? ie_save : ie, mask};

endmodule
